// File: rtl/pe27_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe27_arbiter: round-robin sharing of one pe27_mac between NREQ requesters,   |
// | with operand capture, start sequencing, result routing and a done watchdog.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pe27_arbiter #(
   parameter int          NREQ        = 4,
   parameter int          TIMEOUT     = 1024,
   parameter logic [15:0] JOBS_PRESET = 16'h0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*216-1:0]  req_weights,
   input  logic [NREQ*216-1:0]  req_inputs,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [23:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 mac_start,
   output logic [215:0]         mac_weights,
   output logic [215:0]         mac_inputs,
   input  logic [23:0]          mac_out,
   input  logic                 mac_busy,
   input  logic                 mac_done,
   output logic                 busy,
   output logic [15:0]          jobs_done
);

   localparam int c_idx_w  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_wdog_w = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_idx_w-1:0]    r_owner;
   logic [c_idx_w-1:0]    r_rr_ptr;
   logic [c_wdog_w-1:0]   r_wdog;
   logic [c_idx_w-1:0]    w_idx;
   logic [c_idx_w-1:0]    w_winner;
   logic                  w_found;
   logic [c_idx_w-1:0]    w_owner_inc;
   logic [NREQ-1:0]       w_winner_oh;
   logic [NREQ-1:0]       w_owner_oh;
   logic                  w_grant;
   logic                  w_issue;
   logic                  w_done;
   logic                  w_abort;

   // First requester at or after the round-robin pointer, wrapping mod NREQ.
   always_comb begin
      w_idx    = '0;
      w_winner = '0;
      w_found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = c_idx_w'((int'(r_rr_ptr) + k) % NREQ);
         if (!w_found && req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   assign w_owner_inc = (r_owner == c_idx_w'(NREQ - 1)) ? '0 : r_owner + 1'b1;
   assign w_winner_oh = NREQ'(1) << w_winner;
   assign w_owner_oh  = NREQ'(1) << r_owner;

   assign w_grant = (r_state == S_IDLE)  && w_found;
   assign w_issue = (r_state == S_ISSUE) && !mac_busy;
   assign w_done  = (r_state == S_WAIT)  && mac_done;
   // A done arriving on the last watchdog cycle still counts as a normal result.
   assign w_abort = (r_state == S_WAIT)  && !mac_done && (r_wdog == c_wdog_w'(TIMEOUT - 1));

   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_issue) w_state_nxt = S_WAIT;
         S_WAIT:  if (w_done || w_abort) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_wdog      <= '0;
         gnt         <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         mac_start   <= 1'b0;
         mac_weights <= '0;
         mac_inputs  <= '0;
         jobs_done   <= JOBS_PRESET;
      end else begin
         gnt       <= '0;
         rsp_valid <= '0;
         mac_start <= 1'b0;

         if (w_grant) begin
            r_owner     <= w_winner;
            mac_weights <= req_weights[int'(w_winner)*216 +: 216];
            mac_inputs  <= req_inputs[int'(w_winner)*216 +: 216];
            gnt         <= w_winner_oh;
         end

         if (w_issue) begin
            mac_start <= 1'b1;
            r_wdog    <= '0;
         end

         if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;

         if (w_done) begin
            rsp_data  <= mac_out;
            rsp_err   <= 1'b0;
            rsp_valid <= w_owner_oh;
            r_rr_ptr  <= w_owner_inc;
            if (jobs_done != 16'hFFFF) jobs_done <= jobs_done + 16'd1;
         end else if (w_abort) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= w_owner_oh;
            r_rr_ptr  <= w_owner_inc;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pe27_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pe27_arbiter: self-checking bench with a behavioural pe27_mac stub.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pe27_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*216-1:0] req_weights = '0;
   logic [NREQ*216-1:0] req_inputs = '0;
   logic [NREQ-1:0]     gnt, rsp_valid;
   logic [23:0]         rsp_data;
   logic                rsp_err, mac_start, busy;
   logic [215:0]        mac_weights, mac_inputs;
   logic [15:0]         jobs_done;
   logic [23:0]         mac_out = '0;
   logic                mac_busy = 1'b0;
   logic                mac_done = 1'b0;

   logic [NREQ-1:0]     sat_gnt, sat_rsp_valid;
   logic [23:0]         sat_rsp_data;
   logic                sat_rsp_err, sat_mac_start, sat_busy;
   logic [215:0]        sat_mac_weights, sat_mac_inputs;
   logic [15:0]         sat_jobs_done;

   pe27_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_weights(req_weights), .req_inputs(req_inputs),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mac_start(mac_start), .mac_weights(mac_weights), .mac_inputs(mac_inputs),
      .mac_out(mac_out), .mac_busy(mac_busy), .mac_done(mac_done),
      .busy(busy), .jobs_done(jobs_done)
   );

   // Shadow instance preset near saturation, fed the same inputs.
   pe27_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .JOBS_PRESET(16'hFFFE)) u_sat (
      .clk(clk), .rst_n(rst_n), .req(req), .req_weights(req_weights), .req_inputs(req_inputs),
      .gnt(sat_gnt), .rsp_valid(sat_rsp_valid), .rsp_data(sat_rsp_data), .rsp_err(sat_rsp_err),
      .mac_start(sat_mac_start), .mac_weights(sat_mac_weights), .mac_inputs(sat_mac_inputs),
      .mac_out(mac_out), .mac_busy(mac_busy), .mac_done(mac_done),
      .busy(sat_busy), .jobs_done(sat_jobs_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int m_rr     = 0;
   int m_jobs   = 0;
   int lat_cfg  = 1;
   int hold_cnt = 0;
   int remaining = 0;
   logic [23:0] stub_res = '0;
   logic        prev_start = 1'b0;

   task automatic check(input string name, input logic [215:0] act, input logic [215:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] mac_ref(input logic [215:0] w, input logic [215:0] x);
      int s = 0;
      for (int k = 0; k < 27; k++) s += int'(w[k*8 +: 8]) * int'(x[k*8 +: 8]);
      return 24'(s);
   endfunction

   function automatic logic [15:0] sat_exp(input int base);
      return (base + m_jobs > 65535) ? 16'hFFFF : 16'(base + m_jobs);
   endfunction

   // pe27_mac stand-in: result lat_cfg cycles after start, optional forced busy.
   initial forever begin
      @(negedge clk);
      mac_done = 1'b0;
      if (!rst_n) begin
         remaining = 0;
         hold_cnt  = 0;
         mac_busy  = 1'b0;
      end else begin
         mac_out = 24'($urandom);
         if (mac_start) begin
            remaining = lat_cfg;
            stub_res  = mac_ref(mac_weights, mac_inputs);
         end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
               mac_done = 1'b1;
               mac_out  = stub_res;
            end
         end
         if (hold_cnt > 0) begin
            mac_busy = 1'b1;
            hold_cnt--;
         end else begin
            mac_busy = (remaining > 0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && (gnt != 0 || rsp_valid != 0))
         check("pulse_shape", 216'({$onehot0(gnt), $onehot0(rsp_valid), (gnt == 0) || (rsp_valid == 0)}),
               216'(3'b111));
      if (rst_n && mac_start) check("start_pulse", 216'(prev_start), 216'(0));
      prev_start = mac_start;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic fill_all(input logic [7:0] wf, input logic [7:0] xf);
      for (int l = 0; l < NREQ; l++)
         for (int b = 0; b < 27; b++) begin
            req_weights[l*216 + b*8 +: 8] = wf;
            req_inputs[l*216 + b*8 +: 8]  = xf;
         end
   endtask

   task automatic run_job(input logic [3:0] r, input int lat, input int hold,
                          input logic [3:0] eg, input logic [23:0] ed, input logic ee);
      int   n;
      int   w = 0;
      int   stray = 0;
      logic late;
      for (int k = 0; k < NREQ; k++) if (eg[k]) w = k;
      late = (lat + 1 > TIMEOUT);
      @(negedge clk);
      req = r;
      lat_cfg = lat;
      @(posedge clk); #1;
      check("gnt", 216'(gnt), 216'(eg));
      check("gnt_weights", mac_weights, req_weights[w*216 +: 216]);
      check("gnt_inputs", mac_inputs, req_inputs[w*216 +: 216]);
      req = '0;
      hold_cnt = hold;
      n = 0;
      while (!mac_start && n < 40) begin @(posedge clk); #1; n++; end
      check("start_delay", 216'(n), 216'(hold + 1));
      n = 0;
      while (rsp_valid == 0 && n < 60) begin @(posedge clk); #1; n++; end
      check("rsp_delay", 216'(n), 216'(late ? TIMEOUT : lat + 1));
      check("rsp_valid", 216'(rsp_valid), 216'(eg));
      check("rsp_data", 216'(rsp_data), 216'(ed));
      check("rsp_err", 216'(rsp_err), 216'(ee));
      if (!ee) m_jobs++;
      m_rr = (w + 1) % NREQ;
      @(negedge clk);
      check("jobs_done", 216'(jobs_done), 216'(sat_exp(0)));
      check("jobs_sat", 216'(sat_jobs_done), 216'(sat_exp(65534)));
      if (late) begin
         n = 0;
         while ((remaining > 0 || mac_done) && n < 40) begin
            @(posedge clk); #1;
            if (rsp_valid != 0) stray++;
            n++;
         end
         @(posedge clk); #1;
         check("late_done_ignored", 216'({stray, busy}), 216'(0));
      end
   endtask

   typedef struct {
      logic [3:0]  r;
      logic [7:0]  wf;
      logic [7:0]  xf;
      int          lat;
      int          hold;
      logic [3:0]  eg;
      logic [23:0] ed;
      logic        ee;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int n;
      logic [3:0] r, eg;
      logic [23:0] ed;
      int w, lat, hold;
      bit found;

      tbl[0] = '{4'b0001, 8'h01, 8'h02,  3, 0, 4'b0001, 24'd54,      1'b0};
      tbl[1] = '{4'b1111, 8'hFF, 8'hFF,  2, 0, 4'b0010, 24'd1755675, 1'b0};
      tbl[2] = '{4'b0100, 8'h03, 8'h05,  5, 2, 4'b0100, 24'd405,     1'b0};
      tbl[3] = '{4'b0101, 8'h01, 8'h01,  1, 0, 4'b0001, 24'd27,      1'b0};
      tbl[4] = '{4'b1000, 8'h02, 8'h07, 20, 0, 4'b1000, 24'd0,       1'b1};
      tbl[5] = '{4'b1010, 8'h10, 8'h10, 15, 5, 4'b0010, 24'd6912,    1'b0};
      tbl[6] = '{4'b1001, 8'h80, 8'h03, 16, 1, 4'b1000, 24'd0,       1'b1};
      tbl[7] = '{4'b0110, 8'hFF, 8'h01,  4, 0, 4'b0010, 24'd6885,    1'b0};

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", 216'({gnt, rsp_valid, rsp_data, rsp_err, mac_start, busy, jobs_done}), 216'(0));
      check("reset_sat", 216'(sat_jobs_done), 216'(16'hFFFE));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_no_req", 216'({gnt, busy, mac_start}), 216'(0));

      for (int i = 0; i < 8; i++) begin
         fill_all(tbl[i].wf, tbl[i].xf);
         run_job(tbl[i].r, tbl[i].lat, tbl[i].hold, tbl[i].eg, tbl[i].ed, tbl[i].ee);
      end

      // Reset while the MAC is running.
      fill_all(8'h11, 8'h22);
      lat_cfg = 10;
      @(negedge clk); req = 4'b0100;
      @(posedge clk); #1; req = '0;
      repeat (4) @(posedge clk); #1;
      check("wait_busy", 216'(busy), 216'(1));
      @(negedge clk); rst_n = 1'b0; #1;
      check("midjob_reset", 216'({gnt, rsp_valid, rsp_data, rsp_err, mac_start, busy, jobs_done}), 216'(0));
      check("midjob_reset_ops", mac_weights | mac_inputs, 216'(0));
      @(posedge clk); #1;
      check("midjob_reset_edge", 216'({gnt, rsp_valid, mac_start, busy, jobs_done}), 216'(0));
      check("midjob_reset_sat", 216'(sat_jobs_done), 216'(16'hFFFE));
      @(negedge clk); rst_n = 1'b1;
      m_jobs = 0;
      m_rr = 0;
      repeat (12) @(posedge clk);
      #1 check("post_reset_quiet", 216'({rsp_valid, busy}), 216'(0));

      // Requests held high on all lanes: strict rotation 0,1,2,3,0.
      fill_all(8'hFF, 8'hFF);
      lat_cfg = 2;
      @(negedge clk); req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         eg = 4'(1 << (k % NREQ));
         n = 0;
         while (gnt == 0 && n < 40) begin @(posedge clk); #1; n++; end
         check("rr_gnt", 216'(gnt), 216'(eg));
         if (k == 4) req = '0;
         n = 0;
         while (rsp_valid == 0 && n < 40) begin @(posedge clk); #1; n++; end
         check("rr_rsp_valid", 216'(rsp_valid), 216'(eg));
         check("rr_rsp_data", 216'(rsp_data), 216'(24'd1755675));
         m_jobs++;
         m_rr = (k + 1) % NREQ;
         @(negedge clk);
         check("rr_jobs", 216'(jobs_done), 216'(sat_exp(0)));
      end

      // Randomized jobs against the transaction-level model.
      for (int t = 0; t < 60; t++) begin
         for (int l = 0; l < NREQ; l++)
            for (int b = 0; b < 27; b++) begin
               req_weights[l*216 + b*8 +: 8] = 8'($urandom);
               req_inputs[l*216 + b*8 +: 8]  = 8'($urandom);
            end
         r     = 4'($urandom_range(1, 15));
         lat   = $urandom_range(1, 18);
         hold  = $urandom_range(0, 3);
         found = 1'b0;
         w     = 0;
         for (int k = 0; k < NREQ; k++) begin
            if (!found && r[(m_rr + k) % NREQ]) begin
               found = 1'b1;
               w = (m_rr + k) % NREQ;
            end
         end
         eg = 4'(1 << w);
         ed = (lat + 1 > TIMEOUT) ? 24'd0 : mac_ref(req_weights[w*216 +: 216], req_inputs[w*216 +: 216]);
         run_job(r, lat, hold, eg, ed, lat + 1 > TIMEOUT);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
